// File: rtl/fpmul_pkg.sv
// Shared types and derivation helpers for the streaming floating-point multiplier.
package fpmul_pkg;

  // Control states: collect A, collect B, iterate, normalise, present result
  typedef enum logic [2:0] {
    ST_GET_A = 3'd0,
    ST_GET_B = 3'd1,
    ST_MUL   = 3'd2,
    ST_NORM  = 3'd3,
    ST_OUT   = 3'd4
  } state_e;

  // Result status flags, packed as {nan, ovf, unf}
  typedef struct packed {
    logic nan;
    logic ovf;
    logic unf;
  } fp_flags_t;

  localparam int unsigned FLAGS_W = 3;

  // Total word width {sign, exp, man}
  function automatic int unsigned fp_word_w(input int unsigned exp_w, input int unsigned man_w);
    return 1 + exp_w + man_w;
  endfunction

  // Exponent bias
  function automatic int unsigned fp_bias(input int unsigned exp_w);
    return (2 ** (exp_w - 1)) - 1;
  endfunction

  // All-ones exponent code (inf / NaN)
  function automatic int unsigned fp_exp_max(input int unsigned exp_w);
    return (2 ** exp_w) - 1;
  endfunction

endpackage

// File: rtl/fpmul_shift_add_core.sv
// Sequential unsigned shift-add multiplier: one partial product per cycle,
// N cycles after start, product is valid and done is held until the next start.
module fpmul_shift_add_core #(
  parameter int unsigned N = 24
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   mcand,
  input  logic [N-1:0]   mplier,
  output logic [2*N-1:0] prod,
  output logic           done
);

  localparam int unsigned PW = 2 * N;
  localparam int unsigned CW = $clog2(N + 1);

  logic [PW-1:0] prod_q,   prod_d;
  logic [N-1:0]  mcand_q,  mcand_d;
  logic [N-1:0]  mplier_q, mplier_d;
  logic [CW-1:0] cnt_q,    cnt_d;
  logic          busy_q,   busy_d;
  logic          done_q,   done_d;
  logic [N:0]    sum_c;

  // Next-state: load on start, else add-and-shift-right while busy
  always_comb begin
    prod_d   = prod_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = done_q;
    sum_c    = {1'b0, prod_q[PW-1:N]} + (mplier_q[0] ? {1'b0, mcand_q} : (N+1)'(0));
    if (start) begin
      prod_d   = '0;
      mcand_d  = mcand;
      mplier_d = mplier;
      cnt_d    = '0;
      busy_d   = 1'b1;
      done_d   = 1'b0;
    end else if (busy_q) begin
      prod_d   = {sum_c, prod_q[N-1:1]};
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CW'(1);
      if (cnt_q == CW'(N - 1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  // State registers with synchronous active-low clear
  always_ff @(posedge clk) begin
    if (!rst) begin
      prod_q   <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      prod_q   <= prod_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign prod = prod_q;
  assign done = done_q;

endmodule

// File: rtl/fpmul_stream.sv
// Streaming floating-point multiplier: takes A then B over one handshaked bus,
// multiplies mantissas iteratively, normalises and presents the result.
// Optional macro FPMUL_ROUND_EN: round-to-nearest-even instead of truncation.
module fpmul_stream
  import fpmul_pkg::*;
#(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23,
  localparam int unsigned W    = fp_word_w(EXP_W, MAN_W)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [W-1:0]       in_data,
  input  logic               in_ready,
  output logic               in_accept,
  output logic [W-1:0]       res_data,
  output logic [FLAGS_W-1:0] res_flags,
  output logic               res_ready,
  input  logic               res_accept
);

  localparam int unsigned N       = MAN_W + 1;
  localparam int unsigned PW      = 2 * N;
  localparam int unsigned EW2     = EXP_W + 2;
  localparam int unsigned BIAS    = fp_bias(EXP_W);
  localparam int unsigned EXP_MAX = fp_exp_max(EXP_W);
  localparam logic [W-1:0] QNAN   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  state_e          state_q,     state_d;
  logic [W-1:0]    a_q,         a_d;
  logic [W-1:0]    b_q,         b_d;
  logic [W-1:0]    res_data_q,  res_data_d;
  fp_flags_t       res_flags_q, res_flags_d;
  logic            res_ready_q, res_ready_d;
  logic            in_accept_q, in_accept_d;
  logic            core_start_c;
  logic            core_done;
  logic [PW-1:0]   prod;

  logic            sign_c;
  logic [EXP_W-1:0] exp_a_c, exp_b_c;
  logic            zero_a_c, zero_b_c, inf_a_c, inf_b_c, nan_a_c, nan_b_c;
  logic signed [EW2-1:0] e_sum_c, e_norm_c;
  logic [MAN_W-1:0] man_c;
  logic [W-1:0]    norm_data_c;
  fp_flags_t       norm_flags_c;
`ifdef FPMUL_ROUND_EN
  logic            guard_c, sticky_c;
  logic [MAN_W:0]  man_rnd_c;
`else
  logic            unused_prod_c;
  assign unused_prod_c = ^prod[MAN_W-1:0];
`endif

  // Mantissa multiplier; B mantissa is taken straight off the bus on its transfer edge
  fpmul_shift_add_core #(.N(N)) u_core (
    .clk    (clk),
    .rst    (rst),
    .start  (core_start_c),
    .mcand  ({1'b1, a_q[MAN_W-1:0]}),
    .mplier ({1'b1, in_data[MAN_W-1:0]}),
    .prod   (prod),
    .done   (core_done)
  );

  // Operand classification, exponent arithmetic, normalise/round and special-case selection
  always_comb begin
    sign_c       = a_q[W-1] ^ b_q[W-1];
    exp_a_c      = a_q[W-2 -: EXP_W];
    exp_b_c      = b_q[W-2 -: EXP_W];
    zero_a_c     = (exp_a_c == '0);
    zero_b_c     = (exp_b_c == '0);
    nan_a_c      = (&exp_a_c) && (|a_q[MAN_W-1:0]);
    nan_b_c      = (&exp_b_c) && (|b_q[MAN_W-1:0]);
    inf_a_c      = (&exp_a_c) && !(|a_q[MAN_W-1:0]);
    inf_b_c      = (&exp_b_c) && !(|b_q[MAN_W-1:0]);
    e_sum_c      = EW2'(exp_a_c) + EW2'(exp_b_c) - EW2'(BIAS);
    e_norm_c     = e_sum_c;
    man_c        = '0;
    norm_data_c  = '0;
    norm_flags_c = '0;
`ifdef FPMUL_ROUND_EN
    guard_c      = 1'b0;
    sticky_c     = 1'b0;
    man_rnd_c    = '0;
`endif
    if (prod[PW-1]) begin
      man_c    = prod[PW-2 -: MAN_W];
      e_norm_c = e_sum_c + EW2'(1);
`ifdef FPMUL_ROUND_EN
      guard_c  = prod[MAN_W];
      sticky_c = |prod[MAN_W-1:0];
`endif
    end else begin
      man_c    = prod[PW-3 -: MAN_W];
`ifdef FPMUL_ROUND_EN
      guard_c  = prod[MAN_W-1];
      sticky_c = |prod[MAN_W-2:0];
`endif
    end
`ifdef FPMUL_ROUND_EN
    // Nearest-even: round up above half, or at exactly half when LSB is odd
    if (guard_c && (sticky_c || man_c[0])) begin
      man_rnd_c = {1'b0, man_c} + (MAN_W+1)'(1);
      man_c     = man_rnd_c[MAN_W-1:0];
      if (man_rnd_c[MAN_W]) begin
        e_norm_c = e_norm_c + EW2'(1);
      end
    end
`endif
    if (nan_a_c || nan_b_c || (inf_a_c && zero_b_c) || (zero_a_c && inf_b_c)) begin
      norm_data_c      = QNAN;
      norm_flags_c.nan = 1'b1;
    end else if (inf_a_c || inf_b_c) begin
      norm_data_c = {sign_c, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (zero_a_c || zero_b_c) begin
      norm_data_c = {sign_c, {(W-1){1'b0}}};
    end else if (e_norm_c >= $signed(EW2'(EXP_MAX))) begin
      norm_data_c      = {sign_c, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      norm_flags_c.ovf = 1'b1;
    end else if (e_norm_c <= $signed(EW2'(0))) begin
      norm_data_c      = {sign_c, {(W-1){1'b0}}};
      norm_flags_c.unf = 1'b1;
    end else begin
      norm_data_c = {sign_c, e_norm_c[EXP_W-1:0], man_c};
    end
  end

  // FSM next-state, operand latching and registered output decode
  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    res_data_d   = res_data_q;
    res_flags_d  = res_flags_q;
    core_start_c = 1'b0;
    unique case (state_q)
      ST_GET_A: begin
        if (in_ready) begin
          a_d     = in_data;
          state_d = ST_GET_B;
        end
      end
      ST_GET_B: begin
        if (in_ready) begin
          b_d          = in_data;
          core_start_c = 1'b1;
          state_d      = ST_MUL;
        end
      end
      ST_MUL: begin
        if (core_done) begin
          state_d = ST_NORM;
        end
      end
      ST_NORM: begin
        res_data_d  = norm_data_c;
        res_flags_d = norm_flags_c;
        state_d     = ST_OUT;
      end
      ST_OUT: begin
        if (res_accept) begin
          state_d = ST_GET_A;
        end
      end
      default: state_d = ST_GET_A;
    endcase
    in_accept_d = (state_d == ST_GET_A) || (state_d == ST_GET_B);
    res_ready_d = (state_d == ST_OUT);
  end

  // State and output registers with synchronous active-low clear
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_GET_A;
      a_q         <= '0;
      b_q         <= '0;
      res_data_q  <= '0;
      res_flags_q <= '0;
      res_ready_q <= 1'b0;
      in_accept_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      res_data_q  <= res_data_d;
      res_flags_q <= res_flags_d;
      res_ready_q <= res_ready_d;
      in_accept_q <= in_accept_d;
    end
  end

  assign in_accept = in_accept_q;
  assign res_ready = res_ready_q;
  assign res_data  = res_data_q;
  assign res_flags = res_flags_q;

endmodule

// File: tb/tb_fpmul_stream.sv
// Directed bench for fpmul_stream (EXP_W=8, MAN_W=23).
module tb_fpmul_stream;

  localparam int unsigned W       = 32;
  localparam int          LATENCY = 26;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_ready = 1'b0;
  logic         in_accept;
  logic [W-1:0] res_data;
  logic [2:0]   res_flags;
  logic         res_ready;
  logic         res_accept = 1'b0;

  int tests = 0;
  int fails = 0;

  fpmul_stream #(.EXP_W(8), .MAN_W(23)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .in_accept  (in_accept),
    .res_data   (res_data),
    .res_flags  (res_flags),
    .res_ready  (res_ready),
    .res_accept (res_accept)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  // Present one operand after 'gap' idle cycles; returns right after the transfer edge
  task automatic send(input string tag, input logic [W-1:0] w, input int gap);
    bit xfer = 1'b0;
    bit acc;
    repeat (gap) @(negedge clk);
    for (int i = 0; i < 50 && !xfer; i++) begin
      @(negedge clk);
      in_data  = w;
      in_ready = 1'b1;
      acc      = in_accept;
      @(posedge clk);
      if (acc) xfer = 1'b1;
    end
    check({tag, "_xfer"}, 32'(xfer), 32'd1);
    #1 in_ready = 1'b0;
  endtask

  // Count edges until res_ready is seen high (bounded)
  task automatic wait_result(input string tag, output int lat);
    lat = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1 lat++;
      if (res_ready) break;
    end
    check({tag, "_ready"}, 32'(res_ready), 32'd1);
  endtask

  // Consume the current result and confirm return to operand collection
  task automatic accept_result(input string tag);
    @(negedge clk);
    res_accept = 1'b1;
    @(posedge clk);
    #1;
    check({tag, "_rdy_drop"}, 32'(res_ready), 32'd0);
    check({tag, "_acc_back"}, 32'(in_accept), 32'd1);
    @(negedge clk);
    res_accept = 1'b0;
  endtask

  task automatic run_pair(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp_d, input logic [2:0] exp_f);
    int lat;
    send({tag, "_a"}, a, 0);
    send({tag, "_b"}, b, 0);
    wait_result(tag, lat);
    check({tag, "_lat"}, 32'(lat), 32'(LATENCY));
    check({tag, "_data"}, res_data, exp_d);
    check({tag, "_flags"}, 32'(res_flags), 32'(exp_f));
    accept_result(tag);
  endtask

  initial begin
    logic [W-1:0] round_exp;
    logic [W-1:0] held;
    int           lat;

`ifdef FPMUL_ROUND_EN
    round_exp = 32'h3FC00002;
`else
    round_exp = 32'h3FC00001;
`endif

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    #1;
    check("rst_in_accept", 32'(in_accept), 32'd1);
    check("rst_res_ready", 32'(res_ready), 32'd0);
    check("rst_res_data",  res_data,       32'h0);
    check("rst_res_flags", 32'(res_flags), 32'd0);

    // Arithmetic and special cases
    run_pair("mul_1p5x2",   32'h3FC00000, 32'h40000000, 32'h40400000, 3'b000);
    run_pair("mul_neg",     32'hC0000000, 32'h40400000, 32'hC0C00000, 3'b000);
    run_pair("mul_zero",    32'h00000000, 32'h40400000, 32'h00000000, 3'b000);
    run_pair("mul_ovf",     32'h7F000000, 32'h7F000000, 32'h7F800000, 3'b010);
    run_pair("mul_unf",     32'h00800000, 32'h00800000, 32'h00000000, 3'b001);
    run_pair("mul_infx0",   32'h7F800000, 32'h00000000, 32'h7FC00000, 3'b100);
    run_pair("mul_round",   32'h3F800001, 32'h3FC00000, round_exp,    3'b000);
    run_pair("mul_nan_in",  32'h7FC00001, 32'h3F800000, 32'h7FC00000, 3'b100);
    run_pair("mul_inf_sgn", 32'hFF800000, 32'h40000000, 32'hFF800000, 3'b000);
    run_pair("mul_nzero",   32'h80000000, 32'h40000000, 32'h80000000, 3'b000);

    // Producer gaps, busy input side, consumer back-pressure
    send("gap_a", 32'h3FC00000, 5);
    send("gap_b", 32'h40000000, 5);
    @(posedge clk);
    #1 check("busy_in_accept", 32'(in_accept), 32'd0);
    wait_result("gap", lat);
    check("gap_lat",  32'(lat + 1), 32'(LATENCY));
    check("gap_data", res_data, 32'h40400000);
    held = res_data;
    @(negedge clk);
    in_data  = 32'h12345678;
    in_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("hold_data",  res_data,        held);
      check("hold_ready", 32'(res_ready),  32'd1);
      check("hold_inacc", 32'(in_accept),  32'd0);
    end
    @(negedge clk) in_ready = 1'b0;
    accept_result("gap");

    // Abort mid-multiply, then a fresh pair
    send("abort_a", 32'h7F000000, 0);
    send("abort_b", 32'h7F000000, 0);
    repeat (5) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    check("abort_in_accept", 32'(in_accept), 32'd1);
    check("abort_res_ready", 32'(res_ready), 32'd0);
    @(negedge clk) rst = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    check("abort_idle_ready", 32'(res_ready), 32'd0);
    check("abort_idle_acc",   32'(in_accept), 32'd1);
    run_pair("post_abort", 32'hC0000000, 32'h40400000, 32'hC0C00000, 3'b000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
